// File: rtl/fwd_hazard_if.sv
// Operand-forwarding / hazard bus between the ID stage and fwd_hazard_unit.
// The unit sits on the slave side; the ID stage (or a testbench) sits on the master side.
interface fwd_hazard_if #(
  parameter int unsigned NRD   = 2,
  parameter int unsigned AW    = 5,
  parameter int unsigned DEPTH = 3,
  parameter int unsigned LATW  = 2
);
  localparam int unsigned SELW = $clog2(DEPTH + 1);

  logic                  id_valid;
  logic [AW-1:0]         id_rd;
  logic                  id_regwrite;
  logic [LATW-1:0]       id_lat;
  logic [NRD*AW-1:0]     id_rs;
  logic [NRD-1:0]        id_rren;
  logic                  flush;
  logic                  stall;
  logic [NRD*SELW-1:0]   fwd_sel;

  modport master (
    output id_valid, id_rd, id_regwrite, id_lat, id_rs, id_rren, flush,
    input  stall, fwd_sel
  );

  modport slave (
    input  id_valid, id_rd, id_regwrite, id_lat, id_rs, id_rren, flush,
    output stall, fwd_sel
  );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Forwarding-select and load-use stall generator for an in-order pipeline.
// Tracks DEPTH producer records (stage 0 = EX) and resolves, per read port,
// the youngest producer of each source register.
// Optional feature macro: FWD_WB_BYPASS_EN -- when defined the oldest tracked
// stage (WB) is also a forwarding source; otherwise the register file's
// write-first behaviour covers it and that stage is never matched.
module fwd_hazard_unit #(
  parameter int unsigned NRD   = 2,
  parameter int unsigned AW    = 5,
  parameter int unsigned DEPTH = 3,
  parameter int unsigned LATW  = 2
) (
  input  logic         clk,
  input  logic         reset,
  fwd_hazard_if.slave  bus
);
  localparam int unsigned SELW = $clog2(DEPTH + 1);
`ifdef FWD_WB_BYPASS_EN
  localparam int unsigned NELIG = DEPTH;
`else
  localparam int unsigned NELIG = DEPTH - 1;
`endif

  logic [DEPTH-1:0]    stg_vld;
  logic [DEPTH-1:0]    stg_wr;
  logic [AW-1:0]       stg_rd  [DEPTH];
  logic [LATW-1:0]     stg_cnt [DEPTH];

  logic                hazard;
  logic                stall_int;
  logic                issue;
  logic [SELW-1:0]     sel;
  logic [LATW-1:0]     win_cnt;
  logic [NRD*SELW-1:0] sel_flat;

`ifndef FWD_WB_BYPASS_EN
  // The WB record only retires; fold it so its bits are visibly intentional.
  logic unused_tail;
  assign unused_tail = ^{stg_vld[DEPTH-1], stg_wr[DEPTH-1], stg_rd[DEPTH-1], stg_cnt[DEPTH-1]};
`endif

  // A new record enters EX only for a live, unstalled, unflushed ID instruction.
  assign issue = bus.id_valid & ~stall_int & ~bus.flush;

  // Producer shift register: bubble or new record into EX, older records age with latency countdown.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stg_vld <= '0;
      stg_wr  <= '0;
      for (int k = 0; k < int'(DEPTH); k++) begin
        stg_rd[k]  <= '0;
        stg_cnt[k] <= '0;
      end
    end else begin
      stg_vld[0] <= issue;
      stg_wr[0]  <= bus.id_regwrite;
      stg_rd[0]  <= bus.id_rd;
      stg_cnt[0] <= bus.id_lat;
      for (int k = 1; k < int'(DEPTH); k++) begin
        stg_vld[k] <= stg_vld[k-1];
        stg_wr[k]  <= stg_wr[k-1];
        stg_rd[k]  <= stg_rd[k-1];
        stg_cnt[k] <= (stg_cnt[k-1] == '0) ? '0 : stg_cnt[k-1] - LATW'(1);
      end
    end
  end

  // Per-port match against eligible stages; scanning oldest-first lets the youngest match win.
  always_comb begin
    hazard   = 1'b0;
    sel_flat = '0;
    sel      = '0;
    win_cnt  = '0;
    for (int p = 0; p < int'(NRD); p++) begin
      sel     = '0;
      win_cnt = '0;
      for (int k = int'(NELIG) - 1; k >= 0; k--) begin
        if (bus.id_rren[p] && stg_vld[k] && stg_wr[k] && (stg_rd[k] != '0) &&
            (stg_rd[k] == bus.id_rs[p*AW +: AW])) begin
          sel     = SELW'(k + 1);
          win_cnt = stg_cnt[k];
        end
      end
      sel_flat[p*SELW +: SELW] = sel;
      if ((sel != '0) && (win_cnt != '0)) begin
        hazard = 1'b1;
      end
    end
  end

  assign stall_int   = bus.id_valid & ~bus.flush & hazard;
  assign bus.stall   = stall_int;
  assign bus.fwd_sel = sel_flat;

endmodule

// File: doc/fwd_hazard_unit.md
FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 Parameter NRD, default 2, number of operand read ports.
REQ-002 Parameter AW, default 5, register address width.
REQ-003 Parameter DEPTH, default 3, tracked producer stages after ID (stage 0=EX, 1=MEM, 2=WB); legal range 2..7.
REQ-004 Parameter LATW, default 2, width of the result-latency field.
REQ-005 Derived SELW = clog2(DEPTH+1), width of each forward-select field.
REQ-006 clk  input  1  rising-edge clock; one clock only.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 id_valid  input  1  valid instruction in ID requesting issue.
REQ-009 id_rd  input  AW  destination register of the ID instruction.
REQ-010 id_regwrite  input  1  ID instruction writes id_rd.
REQ-011 id_lat  input  LATW  extra cycles after entering stage 0 before the result is forwardable (0 = ALU, 1 = load); id_lat < DEPTH-1.
REQ-012 id_rs  input  NRD*AW  source registers; port p occupies bits [p*AW +: AW].
REQ-013 id_rren  input  NRD  per-port read enable (port unused when 0).
REQ-014 flush  input  1  kill the ID instruction; insert a bubble into stage 0.
REQ-015 stall  output  1  hold PC and ID; a bubble enters stage 0.
REQ-016 fwd_sel  output  NRD*SELW  per-port source: 0 = register file, k+1 = stage k result.

Function
REQ-017 Block SHALL hold DEPTH records {vld, wr, rd, cnt[LATW]} in a shift register stage[0..DEPTH-1].
REQ-018 Each clock, stage[k] SHALL load stage[k-1] for k>=1, with cnt decremented, saturating at 0.
REQ-019 stage[0] SHALL load {1, id_regwrite, id_rd, id_lat} when id_valid & !stall & !flush; otherwise it SHALL load a bubble (vld=0).
REQ-020 Port p SHALL match stage k when id_rren[p] & stage[k].vld & stage[k].wr & stage[k].rd!=0 & stage[k].rd==id_rs[p].
REQ-021 With several matching stages, the lowest k (youngest producer) SHALL win.
REQ-022 fwd_sel[p] SHALL be k+1 for the winning stage k, or 0 if no stage matches.
REQ-023 stall SHALL be 1 when id_valid & !flush and the winning stage of any port has cnt!=0; otherwise 0.
REQ-024 stall and fwd_sel SHALL be combinational from current inputs and state (zero-cycle latency).
REQ-025 flush SHALL override stall; records already in stage 0..DEPTH-1 SHALL continue to retire unaffected.
REQ-026 Register 0 SHALL never match, for any port or stage.
REQ-027 A stalled instruction SHALL observe stall drop after exactly cnt cycles of its producer, then see fwd_sel = producer stage+1.

Reset
REQ-028 On reset assertion, all stage[].vld SHALL clear asynchronously; stall=0 and fwd_sel=0 immediately.
REQ-029 Reset mid-stall SHALL discard all records; the first post-reset issue SHALL see no hazard.

Configuration
REQ-030 Macro FWD_WB_BYPASS_EN defined: stage DEPTH-1 is eligible for matching; fwd_sel may equal DEPTH.
REQ-031 FWD_WB_BYPASS_EN undefined: stage DEPTH-1 is never matched (register file write-first covers it); fwd_sel never exceeds DEPTH-1.

Verification
REQ-032 DEPTH=3: issue ALU wr r5, next cycle ID reads rs0=r5 -> stall=0, fwd_sel[0]=1.
REQ-033 Issue load r8 (id_lat=1), next ID reads rs1=r8 -> stall=1 for one cycle, then stall=0, fwd_sel[1]=2.
REQ-034 Issue wr r3, then wr r3, then read r3 -> fwd_sel=1 (youngest wins), not 2.
REQ-035 Write r0 with id_regwrite=1, then read r0 on both ports -> fwd_sel=0, stall=0.
REQ-036 Load r4 then read r4 with flush=1 -> stall=0; with reset pulsed during a stall -> stall=0, fwd_sel=0 immediately.
REQ-037 Issue wr r6 then two bubbles, read r6 -> fwd_sel=3 with FWD_WB_BYPASS_EN, 0 without.
